// File: rtl/dma_window_ctrl.sv
// dma_window_ctrl
//   Owns the single-port weight/feature RAM and shares it between a KxK
//   convolution-window fetch sequencer and a single-word writeback client.
//   Writes have strict priority whenever the controller is idle; a fetch
//   runs to completion without interruption.
//
// Ports
//   clk, rst_n                 clock (rising edge) / async active-low reset
//   start_valid/start_ready    fetch request handshake
//   base_addr, row_stride      window origin and row pitch, sampled at accept
//   ksize                      kernel side K, sampled at accept
//   wr_req/wr_addr/wr_data     writeback request, held until wr_gnt
//   wr_gnt                     write performed this cycle
//   mem_en/mem_rw/mem_addr/
//   mem_wdata/mem_rdata        RAM port; read data returns one cycle later
//   win_data                   flat window, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   win_valid/win_err          one-cycle completion pulse / illegal ksize
//   busy                       controller not idle
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | grant writes, accept fetch starts
// READ  | one row-major window read per cycle, capture previous element
// DRAIN | no access, capture the last element
// DONE  | win_valid pulse (win_err if ksize was illegal)

module dma_window_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_K      = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start_valid,
  output logic                                start_ready,
  input  logic [ADDR_WIDTH-1:0]               base_addr,
  input  logic [ADDR_WIDTH-1:0]               row_stride,
  input  logic [2:0]                          ksize,
  input  logic                                wr_req,
  input  logic [ADDR_WIDTH-1:0]               wr_addr,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  output logic                                wr_gnt,
  output logic                                mem_en,
  output logic                                mem_rw,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output logic [DATA_WIDTH-1:0]               mem_wdata,
  input  logic [DATA_WIDTH-1:0]               mem_rdata,
  output logic [MAX_K*MAX_K*DATA_WIDTH-1:0]   win_data,
  output logic                                win_valid,
  output logic                                win_err,
  output logic                                busy
);

  localparam int N_ELEM = MAX_K * MAX_K;
  localparam int IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM + 1) : 1;
  localparam int WIN_W  = N_ELEM * DATA_WIDTH;
  localparam logic [2:0] K_MAX = 3'(MAX_K);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [2:0]            k_q, k_d;
  logic [2:0]            c_q, c_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      rem_q, rem_d;
  logic [IDX_W-1:0]      cap_idx_q, cap_idx_d;
  logic                  cap_q, cap_d;
  logic                  err_q, err_d;
  logic [WIN_W-1:0]      win_q, win_d;

  logic       accept;
  logic       legal_k;
  logic [5:0] ksq;

  assign accept  = (state_q == S_IDLE) && start_valid && !wr_req;
  assign legal_k = (ksize != 3'd0) && (ksize <= K_MAX);
  assign ksq     = {3'b000, ksize} * {3'b000, ksize};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = legal_k ? S_READ : S_DONE;
      S_READ:  if (rem_q == '0) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    start_ready = 1'b0;
    wr_gnt      = 1'b0;
    mem_en      = 1'b0;
    mem_rw      = 1'b1;
    mem_addr    = '0;
    mem_wdata   = '0;
    busy        = 1'b1;
    win_valid   = 1'b0;
    win_err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy        = 1'b0;
        start_ready = !wr_req;
        if (wr_req) begin
          wr_gnt    = 1'b1;
          mem_en    = 1'b1;
          mem_rw    = 1'b0;
          mem_addr  = wr_addr;
          mem_wdata = wr_data;
        end
      end
      S_READ: begin
        mem_en   = 1'b1;
        mem_addr = row_base_q + ADDR_WIDTH'(c_q);
      end
      S_DONE: begin
        win_valid = 1'b1;
        win_err   = err_q;
      end
      default: ;
    endcase
  end

  // address generation, element index pipeline, window capture
  always_comb begin
    stride_d   = stride_q;
    row_base_d = row_base_q;
    k_d        = k_q;
    c_d        = c_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    cap_idx_d  = cap_idx_q;
    cap_d      = 1'b0;
    err_d      = err_q;
    win_d      = win_q;

    if (accept) begin
      err_d = !legal_k;
      if (legal_k) begin
        stride_d   = row_stride;
        row_base_d = base_addr;
        k_d        = ksize;
        c_d        = '0;
        idx_d      = '0;
        rem_d      = IDX_W'(ksq - 6'd1);
        win_d      = '0;
      end
    end

    if (state_q == S_READ) begin
      cap_d     = 1'b1;
      cap_idx_d = idx_q;
      idx_d     = idx_q + 1'b1;
      if (rem_q != '0) rem_d = rem_q - 1'b1;
      if (c_q == k_q - 3'd1) begin
        c_d        = '0;
        row_base_d = row_base_q + stride_q;
      end else begin
        c_d = c_q + 3'd1;
      end
    end

    // read data belongs to the read issued in the previous cycle
    if (cap_q) win_d[int'(cap_idx_q)*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q   <= '0;
      row_base_q <= '0;
      k_q        <= '0;
      c_q        <= '0;
      idx_q      <= '0;
      rem_q      <= '0;
      cap_idx_q  <= '0;
      cap_q      <= 1'b0;
      err_q      <= 1'b0;
      win_q      <= '0;
    end else begin
      stride_q   <= stride_d;
      row_base_q <= row_base_d;
      k_q        <= k_d;
      c_q        <= c_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      cap_idx_q  <= cap_idx_d;
      cap_q      <= cap_d;
      err_q      <= err_d;
      win_q      <= win_d;
    end
  end

  assign win_data = win_q;

endmodule

// File: tb/tb_dma_window_ctrl.sv
module tb_dma_window_ctrl;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MK = 5;
  localparam int WW = MK*MK*DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] row_stride = '0;
  logic [2:0]    ksize = '0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_gnt;
  logic          mem_en;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [WW-1:0] win_data;
  logic          win_valid;
  logic          win_err;
  logic          busy;

  dma_window_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_K(MK)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .base_addr(base_addr), .row_stride(row_stride), .ksize(ksize),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .win_data(win_data), .win_valid(win_valid), .win_err(win_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic rw; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mem_op_t;
  typedef struct { int cyc; logic err; logic [WW-1:0] data; } win_t;

  mem_op_t exp_mem[$];
  win_t    exp_win[$];
  int      busy_lo = 1, busy_hi = 0;
  logic [WW-1:0] last_win = '0;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  // RAM behind the DUT port
  logic [DW-1:0] ram_dut [logic [AW-1:0]];
  function automatic logic [DW-1:0] rd_dut(input logic [AW-1:0] a);
    return ram_dut.exists(a) ? ram_dut[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en && !mem_rw) ram_dut[mem_addr] = mem_wdata;
    if (mem_en && mem_rw) mem_rdata <= rd_dut(mem_addr);
    else                  mem_rdata <= 16'($urandom);
  end

  // reference memory contents as the model believes them
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  function automatic logic [DW-1:0] rd_ref(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a fetch accepted in cycle t reads the window row-major, one
  // address per cycle from t+1, and completes in t+K*K+2; illegal K completes
  // in t+1 leaving the previous window untouched.
  task automatic push_fetch(input int t, input logic [AW-1:0] b, input logic [AW-1:0] s, input int k);
    win_t w;
    mem_op_t m;
    if (k >= 1 && k <= MK) begin
      w.data = '0;
      for (int r = 0; r < k; r++)
        for (int c = 0; c < k; c++) begin
          m.cyc   = t + 1 + r*k + c;
          m.rw    = 1'b1;
          m.addr  = AW'(int'(b) + r*int'(s) + c);
          m.wdata = '0;
          exp_mem.push_back(m);
          w.data[(r*k+c)*DW +: DW] = rd_ref(m.addr);
        end
      w.cyc = t + k*k + 2;
      w.err = 1'b0;
      last_win = w.data;
    end else begin
      w.cyc  = t + 1;
      w.err  = 1'b1;
      w.data = last_win;
    end
    busy_lo = t + 1;
    busy_hi = w.cyc;
    exp_win.push_back(w);
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      mem_op_t m;
      win_t w;
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
      if (mem_en || wr_gnt) begin
        if (exp_mem.size() == 0) chk("mem_unexpected", {wr_gnt, mem_en}, 2'b00);
        else begin
          m = exp_mem.pop_front();
          chk("mem_cycle", cyc, m.cyc);
          chk("mem_op", {wr_gnt, mem_en, mem_rw, mem_addr, (mem_rw ? 16'h0 : mem_wdata)},
                        {~m.rw, 1'b1, m.rw, m.addr, m.wdata});
        end
      end
      if (win_valid) begin
        if (exp_win.size() == 0) chk("win_unexpected", win_valid, 1'b0);
        else begin
          w = exp_win.pop_front();
          chk("win_cycle", cyc, w.cyc);
          chk("win_err", win_err, w.err);
          chk("win_data", win_data, w.data);
        end
      end else if (win_err) chk("win_err_alone", win_err, 1'b0);
    end
  end

  // drivers (entered and left at posedge+1)
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int exp_c);
    mem_op_t m;
    bit got;
    m.cyc = (exp_c < 0) ? cyc : exp_c;
    m.rw = 1'b0; m.addr = a; m.wdata = d;
    exp_mem.push_back(m);
    ref_mem[a] = d;
    wr_addr = a; wr_data = d; wr_req = 1'b1;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wr_gnt) begin got = 1; break; end
    end
    if (!got) chk("wr_gnt_timeout", wr_gnt, 1'b1);
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  task automatic issue_fetch(input logic [AW-1:0] b, input logic [AW-1:0] s, input int k, output int t);
    base_addr = b; row_stride = s; ksize = 3'(k); start_valid = 1'b1;
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (start_ready) begin t = cyc; break; end
    end
    if (t < 0) chk("start_timeout", start_ready, 1'b1);
    else push_fetch(t, b, s, k);
    @(posedge clk); #1;
    start_valid = 1'b0;
    base_addr = 16'($urandom); row_stride = 16'($urandom); ksize = 3'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_mem.size() == 0 && exp_win.size() == 0 && !busy) break;
    end
    chk("drain_pending", exp_mem.size() + exp_win.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, x, k;
    logic [AW-1:0] b, s;

    #12;
    chk("rst_mem", {mem_en, mem_rw, mem_addr, mem_wdata}, {1'b0, 1'b1, 16'h0, 16'h0});
    chk("rst_status", {win_valid, win_err, busy}, 3'b000);
    chk("rst_win", win_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // K=2 window from a small seeded region
    do_write(16'd0, 16'h0004, -1);
    do_write(16'd1, 16'h0003, -1);
    do_write(16'd4, 16'h0008, -1);
    do_write(16'd5, 16'h2000, -1);
    issue_fetch(16'd0, 16'd4, 2, t);
    wait_idle();

    // largest window
    issue_fetch(16'd100, 16'd10, 5, t);
    wait_idle();

    // write and start in the same cycle: write first, start next cycle
    x = cyc;
    base_addr = 16'd8; row_stride = 16'd16; ksize = 3'd2; start_valid = 1'b1;
    begin
      mem_op_t m;
      m.cyc = x; m.rw = 1'b0; m.addr = 16'd8; m.wdata = 16'hF000;
      exp_mem.push_back(m);
      ref_mem[16'd8] = 16'hF000;
    end
    wr_addr = 16'd8; wr_data = 16'hF000; wr_req = 1'b1;
    @(negedge clk);
    chk("start_ready_vs_wr", start_ready, 1'b0);
    @(posedge clk); #1;
    wr_req = 1'b0;
    issue_fetch(16'd8, 16'd16, 2, t);
    chk("start_after_wr", t, x + 1);
    wait_idle();

    // write raised mid-fetch is granted the cycle after DONE
    issue_fetch(16'd20, 16'd7, 3, t);
    @(posedge clk); #1;
    do_write(16'h0014, 16'h1357, t + 9 + 3);
    wait_idle();
    issue_fetch(16'h0012, 16'd1, 3, t);
    wait_idle();

    // illegal sizes
    issue_fetch(16'd40, 16'd3, 0, t);
    wait_idle();
    issue_fetch(16'd40, 16'd3, 6, t);
    wait_idle();

    // address wrap
    issue_fetch(16'hFFFE, 16'd1, 2, t);
    wait_idle();

    // reset in the middle of a fetch
    issue_fetch(16'h0300, 16'd3, 4, t);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_mem.delete();
    exp_win.delete();
    busy_lo = 1; busy_hi = 0;
    last_win = '0;
    #1;
    chk("midrst_mem", {mem_en, mem_rw, mem_addr, mem_wdata}, {1'b0, 1'b1, 16'h0, 16'h0});
    chk("midrst_status", {win_valid, win_err, busy}, 3'b000);
    chk("midrst_win", win_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    issue_fetch(16'd50, 16'd2, 7, t);
    wait_idle();

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        do_write(16'($urandom_range(0, 127)), 16'($urandom), -1);
      end else begin
        k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 5));
        b = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127));
        s = 16'($urandom_range(0, 40));
        issue_fetch(b, s, k, t);
        if (k >= 1 && k <= MK && $urandom_range(0, 2) == 0) begin
          @(posedge clk); #1;
          do_write(16'($urandom_range(0, 127)), 16'($urandom), t + k*k + 3);
        end
      end
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dma_window_ctrl.md
Name: dma_window_ctrl

Overview:
Controller that owns the single-port weight/feature RAM interface (enable, RW, address, write data) and shares it between two clients. A convolution-window fetch sequencer reads a KxK window (K ≤ MAX_K) into a flat window register for the PE array. A writeback client issues single-word writes. An FSM handles sequencing, address generation, read-latency alignment and arbitration.

Parameters:
ADDR_WIDTH, 16, memory address width
DATA_WIDTH, 16, signed word width
MAX_K, 5, largest kernel side; window holds MAX_K*MAX_K words

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  fetch request
start_ready  output  1  fetch request accepted when start_valid && start_ready
base_addr  input  ADDR_WIDTH  address of window element (0,0), sampled at accept
row_stride  input  ADDR_WIDTH  address distance between window rows, sampled at accept
ksize  input  3  kernel side K, sampled at accept
wr_req  input  1  writeback request
wr_addr  input  ADDR_WIDTH  writeback address
wr_data  input  DATA_WIDTH  writeback data
wr_gnt  output  1  write performed this cycle (combinational grant)
mem_en  output  1  memory enable
mem_rw  output  1  1 = read, 0 = write
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  read data, valid the cycle after a read is issued
win_data  output  MAX_K*MAX_K*DATA_WIDTH  window; element i at bits [i*DATA_WIDTH +: DATA_WIDTH]
win_valid  output  1  one-cycle pulse: window complete
win_err  output  1  one-cycle pulse with win_valid: illegal ksize
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE. win_data=0, win_valid=0, win_err=0, busy=0, all counters 0. mem_en=0, mem_rw=1, mem_addr=0, mem_wdata=0.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start_ready = !wr_req. Writes have strict priority over fetch starts.
  - wr_gnt = wr_req. On a grant, drive mem_en=1, mem_rw=0, mem_addr=wr_addr, mem_wdata=wr_data that same cycle. Otherwise mem_en=0.
  - Start accept with 1≤ksize≤MAX_K: latch base_addr, row_stride and K. Clear win_data to 0 so unused entries read as zero. Clear r=c=0. Go to READ.
  - Start accept with ksize=0 or ksize>MAX_K: no memory access. Go to DONE with the error flag set.
- READ, one read per cycle:
  - mem_en=1, mem_rw=1, mem_addr = base + r*row_stride + c, truncated modulo 2^ADDR_WIDTH (wrap-around is legal).
  - Issue order is row-major. c increments; at c=K-1, c resets to 0 and r increments.
  - The element index i = r*K+c is pipelined one cycle. mem_rdata is written into win_data element i on the following cycle.
  - After issuing element K*K-1, go to DRAIN.
  - wr_gnt=0 and start_ready=0 throughout.
- DRAIN: mem_en=0. Capture the last element. Go to DONE.
- DONE: win_valid=1 for exactly one cycle, win_err=error flag, then go to IDLE. win_data holds until the next legal start is accepted.
- Latency: accept at cycle T. Reads issue in T+1 .. T+K*K. win_valid is high in cycle T+K*K+2. Illegal ksize: win_valid and win_err are high in T+1.
- start_valid while busy is ignored; the requester must hold it. wr_req while busy is stalled (wr_gnt=0); the requester holds wr_req, wr_addr and wr_data until granted.
- Simultaneous wr_req and start_valid in IDLE: the write is granted and the start waits. Back-to-back writes can starve fetches; this is by design (the writeback drains first).
- Reset mid-fetch: the fetch is abandoned immediately, win_data is cleared, and no win_valid is produced.
- mem_rdata is captured only in the cycle after a read issue. It is ignored after writes.

Test Plan:
- Reset, then K=2, base=0, stride=4, with RAM[0,1,4,5]=4,3,8,0x2000 -> reads of 0,1,4,5 in T+1..T+4; win_valid in T+6. Elements 0..3 = 0x0004, 0x0003, 0x0008, 0x2000; elements 4..24 = 0.
- K=5, base=100, stride=10 -> 25 reads at addresses 100..104, 110..114, …, 140..144; win_valid in T+27; win_err=0; busy high T+1..T+27.
- wr_req (addr=8, data=0xF000) asserted in the same cycle as start_valid -> wr_gnt=1, mem_rw=0 and the write is performed; start_ready=0. The start is accepted the next cycle, and a later fetch of address 8 returns 0xF000.
- wr_req raised in mid-fetch -> wr_gnt stays 0 until the cycle after the DONE cycle. Granted then, the write occurs exactly once.
- ksize=0, then ksize=6 -> no mem_en; win_valid=win_err=1 at T+1; win_data unchanged from the prior window.
- base=0xFFFE, stride=1, K=2 -> addresses 0xFFFE, 0xFFFF, 0xFFFF, 0x0000. Then rst_n pulsed low at T+2 of a new fetch -> outputs return to reset values immediately, with no win_valid.
